// File: rtl/hilo_sequencer_pkg.sv
// Shared state encoding, opcode values and counter sizing for the HI/LO sequencer.
package hilo_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DZERO = 3'd4
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  // Counter must be able to hold MAX_CYCLES itself.
  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/hilo_sequencer_if.sv
// Bundle of control-unit request, Multi/Div unit and HI/LO register signals.
interface hilo_seq_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic              timeout;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              mult_start;
  logic              mult_done;
  logic [DATA_W-1:0] mult_hi;
  logic [DATA_W-1:0] mult_lo;
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;
  logic              hi_write;
  logic              lo_write;
  logic [DATA_W-1:0] hi_data;
  logic [DATA_W-1:0] lo_data;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  mult_done, mult_hi, mult_lo, div_done, div_hi, div_lo,
    output busy, done, div_zero, timeout, unit_a, unit_b,
    output mult_start, div_start, hi_write, lo_write, hi_data, lo_data
  );

  // Control unit / execution unit side
  modport master (
    output req_valid, req_op, req_a, req_b,
    output mult_done, mult_hi, mult_lo, div_done, div_hi, div_lo,
    input  busy, done, div_zero, timeout, unit_a, unit_b,
    input  mult_start, div_start, hi_write, lo_write, hi_data, lo_data
  );
endinterface

// File: rtl/hilo_sequencer_watchdog.sv
// Saturating WAIT-cycle counter with MAX_CYCLES limit flag (built only with HILO_SEQ_TIMEOUT_EN).
module hilo_seq_watchdog #(
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_limit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_limit = (r_cnt == CNT_W'(MAX_CYCLES));

endmodule

// File: rtl/hilo_sequencer.sv
// Sequences one MULT/DIV through the shared units and writes HI/LO; optional watchdog via HILO_SEQ_TIMEOUT_EN.
module hilo_sequencer
  import hilo_seq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_CYCLES = 64
) (
  input logic       clock,
  input logic       reset,
  hilo_seq_if.slave bus
);

  localparam int CNT_W = cnt_width(MAX_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic              r_is_div;
  logic [DATA_W-1:0] r_unit_a;
  logic [DATA_W-1:0] r_unit_b;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic w_accept;
  logic w_sel_done;
  logic w_clear;
  logic w_inc;
  logic w_limit;
  logic w_capture;
  logic w_busy;
  logic w_write;
  logic w_div_zero;
  logic w_mult_start;
  logic w_div_start;

  // The unit that was not started is never listened to.
  assign w_sel_done = r_is_div ? bus.div_done : bus.mult_done;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    w_inc        = 1'b0;
    w_capture    = 1'b0;
    w_busy       = 1'b1;
    w_write      = 1'b0;
    w_div_zero   = 1'b0;
    w_mult_start = 1'b0;
    w_div_start  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.req_valid && !bus.req_op[1]) begin
          w_accept = 1'b1;
          w_next   = ((bus.req_op == OP_DIV) && (bus.req_b == '0)) ? DZERO : ISSUE;
        end
      end
      ISSUE: begin
        w_mult_start = !r_is_div;
        w_div_start  = r_is_div;
        w_clear      = 1'b1;
        w_next       = WAIT;
      end
      WAIT: begin
        if (w_sel_done) begin
          w_capture = 1'b1;
          w_next    = WRITE;
        end else if (w_limit) begin
          w_next = IDLE;
        end else begin
          w_inc = 1'b1;
        end
      end
      WRITE: begin
        w_write = 1'b1;
        w_next  = IDLE;
      end
      DZERO: begin
        w_div_zero = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_unit_a <= '0;
      r_unit_b <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_is_div <= (bus.req_op == OP_DIV);
        r_unit_a <= bus.req_a;
        r_unit_b <= bus.req_b;
      end
      if (w_capture) begin
        r_hi <= r_is_div ? bus.div_hi : bus.mult_hi;
        r_lo <= r_is_div ? bus.div_lo : bus.mult_lo;
      end
    end
  end

`ifdef HILO_SEQ_TIMEOUT_EN
  logic r_timeout;

  hilo_seq_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_limit (w_limit)
  );

  // A done coinciding with the limit wins, so the abort is qualified by it.
  always_ff @(posedge clock) begin
    if (reset) r_timeout <= 1'b0;
    else       r_timeout <= (r_state == WAIT) && w_limit && !w_sel_done;
  end

  assign bus.timeout = r_timeout;
`else
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (w_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_limit     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.busy       = w_busy;
  assign bus.done       = w_write;
  assign bus.hi_write   = w_write;
  assign bus.lo_write   = w_write;
  assign bus.div_zero   = w_div_zero;
  assign bus.mult_start = w_mult_start;
  assign bus.div_start  = w_div_start;
  assign bus.unit_a     = r_unit_a;
  assign bus.unit_b     = r_unit_b;
  assign bus.hi_data    = r_hi;
  assign bus.lo_data    = r_lo;

endmodule

// File: doc/hilo_sequencer.md
Name: hilo_sequencer

Overview:
- Sequences the shared multiply and divide units and owns the only write path into the HI/LO registers.
- Sits between the multicycle control unit and the Multi/Div units.
- The control unit issues one MULT/DIV request; this block latches the operands, pulses the selected unit's start, and waits for that unit's done.
- It then routes that unit's HI/LO results to the HI/LO registers with a single write pulse, or reports divide-by-zero.

Parameters:
- DATA_W, 32, operand and result width.
- MAX_CYCLES, 64, watchdog limit in WAIT cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request from control unit
- req_op  in  2  00=MULT, 01=DIV, 1x=reserved
- req_a  in  DATA_W  operand A (rs)
- req_b  in  DATA_W  operand B (rt)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; HI/LO written this cycle
- div_zero  out  1  one-cycle pulse; DIV by zero, no HI/LO write
- timeout  out  1  one-cycle pulse; watchdog abort
- unit_a  out  DATA_W  latched operand A to both units
- unit_b  out  DATA_W  latched operand B to both units
- mult_start  out  1  start pulse to Multi
- mult_done  in  1  Multi finished; results valid this cycle
- mult_hi  in  DATA_W  Multi HI result
- mult_lo  in  DATA_W  Multi LO result
- div_start  out  1  start pulse to Div
- div_done  in  1  Div finished; results valid this cycle
- div_hi  in  DATA_W  Div remainder
- div_lo  in  DATA_W  Div quotient
- hi_write  out  1  load enable for HI register
- lo_write  out  1  load enable for LO register
- hi_data  out  DATA_W  data to HI register
- lo_data  out  DATA_W  data to LO register

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values:
  - state=IDLE.
  - All pulses, busy, hi_write and lo_write are 0.
  - unit_a, unit_b, hi_data and lo_data are 0.
  - The cycle counter is 0.
- Reset asserted in any state returns the block to IDLE on the next edge. An in-flight operation is abandoned and no HI/LO write occurs.
- States: IDLE, ISSUE, WAIT, WRITE, DZERO.
- IDLE:
  - On req_valid with req_op in {00,01}, latch req_a/req_b into unit_a/unit_b and latch the op.
  - DIV with req_b==0 goes to DZERO; all other valid requests go to ISSUE.
  - Reserved op: request ignored; stay IDLE; no output changes.
- req_valid is ignored whenever busy=1. Operands stay stable on unit_a/unit_b from acceptance until return to IDLE.
- ISSUE (exactly 1 cycle):
  - Assert mult_start or div_start according to the latched op. Only one of the two is ever asserted.
  - Next state is WAIT; the counter clears.
- WAIT:
  - Only the selected unit's done is honoured. The other unit's done is ignored.
  - On the selected done, capture that unit's hi/lo into hi_data/lo_data and go to WRITE.
  - Otherwise increment the counter and stay.
- WRITE (1 cycle): hi_write=lo_write=1 and done=1; then IDLE. hi_data/lo_data hold their values until the next capture.
- DZERO (1 cycle): div_zero=1, no unit started, no HI/LO write; then IDLE.
- Latency:
  - Request sampled at edge T; start pulse during cycle T+1.
  - If the unit's done arrives in the k-th WAIT cycle, done/hi_write pulse in cycle T+2+k.
  - Minimum request-to-done is 3 cycles; DZERO pulses at T+1.
- A done input arriving during ISSUE is not honoured. Units guarantee done no earlier than one cycle after start.
- The counter saturates at its maximum value and never wraps.

Optional Feature:
- Macro: HILO_SEQ_TIMEOUT_EN.
- When defined:
  - If the counter reaches MAX_CYCLES in WAIT without the selected done, assert timeout for 1 cycle and return to IDLE.
  - There is no HI/LO write and no done.
  - A done arriving in the same cycle as the limit wins: WRITE is taken, not timeout.
- When undefined: WAIT waits indefinitely, timeout is tied to 0, and no compare logic is built.

Decomposition:
- Package hilo_seq_pkg:
  - state enum (IDLE, ISSUE, WAIT, WRITE, DZERO);
  - op localparams OP_MULT=2'b00 and OP_DIV=2'b01;
  - counter width derived as $clog2(MAX_CYCLES+1).
- One sub-module: hilo_seq_watchdog, containing the saturating counter and limit compare. It is instantiated only under HILO_SEQ_TIMEOUT_EN; the counter is otherwise inline.

Test Plan:
1. MULT: a=7, b=6; mult_done in 3rd WAIT cycle with hi=0, lo=42. Expect mult_start at T+1 only; hi_write=lo_write=done at T+5; hi_data=0, lo_data=42; div_start never asserted.
2. DIV: a=17, b=5; div_done with hi=2, lo=3. Expect div_start once; HI=2, LO=3 written with a single done pulse.
3. DIV by zero: a=9, b=0. Expect div_zero at T+1; no div_start, hi_write or done; busy low at T+2.
4. Request ignored while busy: a second req_valid (MULT, a=1, b=1) during WAIT. Expect unit_a/unit_b unchanged and exactly one done. A reserved op=2'b10 in IDLE produces no activity.
5. Stray done and mid-operation reset:
   - div_done during a MULT WAIT is ignored.
   - reset asserted in WAIT gives IDLE the next cycle, with all outputs 0 and no hi_write.
6. Timeout (HILO_SEQ_TIMEOUT_EN, MAX_CYCLES=4): MULT with mult_done held low. Expect timeout pulse after 4 WAIT cycles, no HI/LO write, then IDLE. With done coinciding with the limit cycle, expect WRITE and no timeout.
